// File: rtl/multicycle_controller_if.sv
// Purpose: groups the controller's instruction fields, status flags, memory handshake and datapath controls.
// Latency: none, signal bundle only.
// Backpressure: i_memReady completes the access that o_memReq requests; the controller holds its request until then.
interface multicycle_controller_if #(
    parameter int ALU_CONTROL_W = 4
);
    logic [6:0]               i_op;
    logic [2:0]               i_funct3;
    logic                     i_funct7bit5;
    logic                     i_zero;
    logic                     i_memReady;
    logic                     o_memReq;
    logic                     o_memWrite;
    logic                     o_adrSrc;
    logic                     o_irWrite;
    logic                     o_pcWrite;
    logic                     o_regWrite;
    logic [1:0]               o_resultSrc;
    logic [1:0]               o_aluSrcA;
    logic [1:0]               o_aluSrcB;
    logic [1:0]               o_immSrc;
    logic [ALU_CONTROL_W-1:0] o_aluControl;
    logic                     o_illegal;

    // controller side
    modport master (
        input  i_op, i_funct3, i_funct7bit5, i_zero, i_memReady,
        output o_memReq, o_memWrite, o_adrSrc, o_irWrite, o_pcWrite, o_regWrite,
        output o_resultSrc, o_aluSrcA, o_aluSrcB, o_immSrc, o_aluControl, o_illegal
    );

    // datapath / memory side
    modport slave (
        output i_op, i_funct3, i_funct7bit5, i_zero, i_memReady,
        input  o_memReq, o_memWrite, o_adrSrc, o_irWrite, o_pcWrite, o_regWrite,
        input  o_resultSrc, o_aluSrcA, o_aluSrcB, o_immSrc, o_aluControl, o_illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Purpose: multicycle RV32I control FSM (lw, sw, R-type, I-type ALU, beq, jal), sticky trap on illegal ops; RV_BNE_EN adds bne.
// Latency: outputs decoded from the current state; 3 to 5 cycles per instruction plus memory wait cycles.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold their request until i_memReady; WAIT_TIMEOUT stalled cycles trap (0 = wait forever).
module multicycle_controller #(
    parameter int ALU_CONTROL_W = 4,
    parameter int WAIT_TIMEOUT  = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    localparam int CNT_W      = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam int CNT_LAST_I = (WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             timeout;
    logic             branch_ok;
    logic             branch_taken;
    logic [3:0]       alu_r, alu_i, alu_code;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;

    // the stall that would bring the count to WAIT_TIMEOUT traps instead, unless ready arrives with it
    assign timeout = (WAIT_TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    assign alu_r = {bus.i_funct7bit5, bus.i_funct3};
    assign alu_i = (bus.i_funct3 == 3'b101) ? {bus.i_funct7bit5, 3'b101} : {1'b0, bus.i_funct3};

`ifdef RV_BNE_EN
    assign branch_ok    = (bus.i_funct3 == 3'b000) || (bus.i_funct3 == 3'b001);
    assign branch_taken = (bus.i_funct3 == 3'b001) ? ~bus.i_zero : bus.i_zero;
`else
    assign branch_ok    = (bus.i_funct3 == 3'b000);
    assign branch_taken = bus.i_zero;
`endif

    // state and wait-counter registers, synchronous reset back to FETCH
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // next-state and control decode; counter is zero unless a waiting state stays put
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        illegal      = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_code     = ALU_ADD;

        case (bus.i_op)
            OP_SW:   imm_src = 2'b01;
            OP_BR:   imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase

        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (bus.i_memReady) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timeout) begin
                    state_nxt = S_TRAP;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.i_op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECUTER;
                    OP_I:         state_nxt = S_EXECUTEI;
                    OP_BR:        state_nxt = branch_ok ? S_BRANCH : S_TRAP;
                    OP_JAL:       state_nxt = S_JAL;
                    default:      state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = (bus.i_op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD, S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = (state == S_MEMWRITE);
                adr_src   = 1'b1;
                if (bus.i_memReady) begin
                    state_nxt = (state == S_MEMWRITE) ? S_FETCH : S_MEMWB;
                end else if (timeout) begin
                    state_nxt = S_TRAP;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_code  = alu_r;
                state_nxt = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_code  = alu_i;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_code  = ALU_SUB;
                pc_write  = branch_taken;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target precomputed in DECODE; ALUWB then writes oldPC+4 to rd
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase

        // reset silences every enable and the trap flag in the cycle it is asserted
        if (i_rst) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign bus.o_memReq      = mem_req;
    assign bus.o_memWrite    = mem_write;
    assign bus.o_adrSrc      = adr_src;
    assign bus.o_irWrite     = ir_write;
    assign bus.o_pcWrite     = pc_write;
    assign bus.o_regWrite    = reg_write;
    assign bus.o_resultSrc   = result_src;
    assign bus.o_aluSrcA     = alu_src_a;
    assign bus.o_aluSrcB     = alu_src_b;
    assign bus.o_immSrc      = imm_src;
    assign bus.o_aluControl  = ALU_CONTROL_W'(alu_code);
    assign bus.o_illegal     = illegal;
endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose: self-checking bench for multicycle_controller, per-cycle expected control words through a scoreboard queue.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge of the same cycle.
// Backpressure: i_memReady is scripted per cycle, including stalls up to and past the 4-cycle wait timeout.
module tb_multicycle_controller;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct packed {
        logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
        logic [1:0] result_src, src_a, src_b, imm_src;
        logic [3:0] alu;
        logic       illegal;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, zero, rdy;
    } stim_t;

    logic clk;
    logic rst;
    obs_t dut_obs;
    obs_t exp_o;
    stim_t s_l[$];
    obs_t  e_l[$];
    obs_t  m_l[$];
    obs_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    multicycle_controller_if #(.ALU_CONTROL_W(4)) bus ();

    multicycle_controller #(.ALU_CONTROL_W(4), .WAIT_TIMEOUT(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    assign dut_obs = {bus.o_memReq, bus.o_memWrite, bus.o_adrSrc, bus.o_irWrite, bus.o_pcWrite,
                      bus.o_regWrite, bus.o_resultSrc, bus.o_aluSrcA, bus.o_aluSrcB, bus.o_immSrc,
                      bus.o_aluControl, bus.o_illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        case (op)
            SW:      return 2'b01;
            BR:      return 2'b10;
            JL:      return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic obs_t mk(input logic mr, mw, as, ir, pw, rw, input logic [1:0] rs, a, b,
                                input logic [6:0] op, input logic [3:0] alu, input logic ill);
        obs_t o;
        o = {mr, mw, as, ir, pw, rw, rs, a, b, imm_of(op), alu, ill};
        return o;
    endfunction

    function automatic obs_t m_all();
        obs_t m;
        m = '1;
        return m;
    endfunction

    // reset and trap only pin down the enables and the trap flag
    function automatic obs_t m_en();
        obs_t m;
        m = '0;
        m.mem_req = 1'b1; m.mem_write = 1'b1; m.ir_write = 1'b1;
        m.pc_write = 1'b1; m.reg_write = 1'b1; m.illegal = 1'b1;
        return m;
    endfunction

    function automatic obs_t e_fetch(input logic [6:0] op, input logic rdy);
        return mk(1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, op, 4'b0000, 0);
    endfunction
    function automatic obs_t e_decode(input logic [6:0] op);
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, op, 4'b0000, 0);
    endfunction
    function automatic obs_t e_memadr(input logic [6:0] op);
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, op, 4'b0000, 0);
    endfunction
    function automatic obs_t e_mem(input logic [6:0] op, input logic wr);
        return mk(1, wr, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, op, 4'b0000, 0);
    endfunction
    function automatic obs_t e_wb(input logic [6:0] op, input logic [1:0] rs);
        return mk(0, 0, 0, 0, 0, 1, rs, 2'b00, 2'b00, op, 4'b0000, 0);
    endfunction
    function automatic obs_t e_exec(input logic [6:0] op, input logic [1:0] b, input logic [3:0] alu);
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, b, op, alu, 0);
    endfunction
    function automatic obs_t e_branch(input logic pw);
        return mk(0, 0, 0, 0, pw, 0, 2'b00, 2'b10, 2'b00, BR, 4'b1000, 0);
    endfunction
    function automatic obs_t e_jal();
        return mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, JL, 4'b0000, 0);
    endfunction
    function automatic obs_t e_quiet(input logic ill);
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 7'd0, 4'b0000, ill);
    endfunction

    function automatic stim_t st(input logic r, input logic [6:0] op, input logic [2:0] f3,
                                 input logic f7, z, rdy);
        stim_t s;
        s = {r, op, f3, f7, z, rdy};
        return s;
    endfunction

    task automatic add(input stim_t s, input obs_t e, input obs_t m);
        s_l.push_back(s);
        e_l.push_back(e);
        m_l.push_back(m);
    endtask

    task automatic clear_lists();
        s_l.delete();
        e_l.delete();
        m_l.delete();
    endtask

    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        rst              = s.rst;
        bus.i_op         = s.op;
        bus.i_funct3     = s.f3;
        bus.i_funct7bit5 = s.f7;
        bus.i_zero       = s.zero;
        bus.i_memReady   = s.rdy;
    endtask

    // straight-line instruction: FETCH, DECODE, execute state, ALUWB
    task automatic add_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic [3:0] alu);
        add(st(0, op, f3, f7, 0, 1), e_fetch(op, 1), m_all());
        add(st(0, op, f3, f7, 0, 1), e_decode(op), m_all());
        add(st(0, op, f3, f7, 0, 1), e_exec(op, (op == RT) ? 2'b00 : 2'b01, alu), m_all());
        add(st(0, op, f3, f7, 0, 1), e_wb(op, 2'b00), m_all());
    endtask

    task automatic add_reset();
        add(st(1, RT, 3'b000, 0, 0, 1), e_quiet(0), m_en());
    endtask

    task automatic test_reset();
        clear_lists();
        add_reset();
        add_reset();
        for (int i = 0; i < s_l.size(); i++) begin
            drive(s_l[i]);
            sb.push_back(e_l[i]);
            @(negedge clk);
            exp_o = sb.pop_front();
            n_cmp++;
            if ((dut_obs & m_l[i]) !== (exp_o & m_l[i])) begin
                n_bad++;
                $display("FAIL reset cyc%0d got=%h want=%h", i, dut_obs & m_l[i], exp_o & m_l[i]);
            end
        end
    endtask

    task automatic test_alu();
        clear_lists();
        add_alu(RT, 3'b000, 1, 4'b1000);
        add_alu(RT, 3'b000, 0, 4'b0000);
        add_alu(RT, 3'b111, 0, 4'b0111);
        add_alu(IT, 3'b000, 1, 4'b0000);
        add_alu(IT, 3'b101, 1, 4'b1101);
        add_alu(IT, 3'b101, 0, 4'b0101);
        add_alu(IT, 3'b010, 1, 4'b0010);
        for (int i = 0; i < s_l.size(); i++) begin
            drive(s_l[i]);
            sb.push_back(e_l[i]);
            @(negedge clk);
            exp_o = sb.pop_front();
            n_cmp++;
            if ((dut_obs & m_l[i]) !== (exp_o & m_l[i])) begin
                n_bad++;
                $display("FAIL alu cyc%0d got=%h want=%h", i, dut_obs & m_l[i], exp_o & m_l[i]);
            end
        end
    endtask

    task automatic test_load_store();
        clear_lists();
        add(st(0, LW, 3'b010, 0, 0, 1), e_fetch(LW, 1), m_all());
        add(st(0, LW, 3'b010, 0, 0, 1), e_decode(LW), m_all());
        add(st(0, LW, 3'b010, 0, 0, 1), e_memadr(LW), m_all());
        for (int k = 0; k < 3; k++) add(st(0, LW, 3'b010, 0, 0, 0), e_mem(LW, 0), m_all());
        add(st(0, LW, 3'b010, 0, 0, 1), e_mem(LW, 0), m_all());
        add(st(0, LW, 3'b010, 0, 0, 1), e_wb(LW, 2'b01), m_all());
        add(st(0, SW, 3'b010, 0, 0, 1), e_fetch(SW, 1), m_all());
        add(st(0, SW, 3'b010, 0, 0, 1), e_decode(SW), m_all());
        add(st(0, SW, 3'b010, 0, 0, 1), e_memadr(SW), m_all());
        for (int k = 0; k < 2; k++) add(st(0, SW, 3'b010, 0, 0, 0), e_mem(SW, 1), m_all());
        add(st(0, SW, 3'b010, 0, 0, 1), e_mem(SW, 1), m_all());
        add(st(0, SW, 3'b010, 0, 0, 0), e_fetch(SW, 0), m_all());
        add(st(0, SW, 3'b010, 0, 0, 1), e_fetch(SW, 1), m_all());
        add(st(0, SW, 3'b010, 0, 0, 1), e_decode(SW), m_all());
        add(st(0, SW, 3'b010, 0, 0, 1), e_memadr(SW), m_all());
        add(st(0, SW, 3'b010, 0, 0, 1), e_mem(SW, 1), m_all());
        for (int i = 0; i < s_l.size(); i++) begin
            drive(s_l[i]);
            sb.push_back(e_l[i]);
            @(negedge clk);
            exp_o = sb.pop_front();
            n_cmp++;
            if ((dut_obs & m_l[i]) !== (exp_o & m_l[i])) begin
                n_bad++;
                $display("FAIL ldst cyc%0d got=%h want=%h", i, dut_obs & m_l[i], exp_o & m_l[i]);
            end
        end
    endtask

    task automatic test_branch_jal();
        clear_lists();
        for (int k = 0; k < 2; k++) begin
            add(st(0, BR, 3'b000, 0, k == 0, 1), e_fetch(BR, 1), m_all());
            add(st(0, BR, 3'b000, 0, k == 0, 1), e_decode(BR), m_all());
            add(st(0, BR, 3'b000, 0, k == 0, 1), e_branch(k == 0), m_all());
        end
        add(st(0, JL, 3'b000, 0, 0, 1), e_fetch(JL, 1), m_all());
        add(st(0, JL, 3'b000, 0, 0, 1), e_decode(JL), m_all());
        add(st(0, JL, 3'b000, 0, 0, 1), e_jal(), m_all());
        add(st(0, JL, 3'b000, 0, 0, 1), e_wb(JL, 2'b00), m_all());
`ifdef RV_BNE_EN
        for (int k = 0; k < 2; k++) begin
            add(st(0, BR, 3'b001, 0, k == 1, 1), e_fetch(BR, 1), m_all());
            add(st(0, BR, 3'b001, 0, k == 1, 1), e_decode(BR), m_all());
            add(st(0, BR, 3'b001, 0, k == 1, 1), e_branch(k == 0), m_all());
        end
`else
        add(st(0, BR, 3'b001, 0, 0, 1), e_fetch(BR, 1), m_all());
        add(st(0, BR, 3'b001, 0, 0, 1), e_decode(BR), m_all());
        add(st(0, BR, 3'b001, 0, 0, 1), e_quiet(1), m_en());
        add(st(0, BR, 3'b001, 0, 1, 1), e_quiet(1), m_en());
        add_reset();
`endif
        for (int i = 0; i < s_l.size(); i++) begin
            drive(s_l[i]);
            sb.push_back(e_l[i]);
            @(negedge clk);
            exp_o = sb.pop_front();
            n_cmp++;
            if ((dut_obs & m_l[i]) !== (exp_o & m_l[i])) begin
                n_bad++;
                $display("FAIL branch cyc%0d got=%h want=%h", i, dut_obs & m_l[i], exp_o & m_l[i]);
            end
        end
    endtask

    task automatic test_illegal();
        clear_lists();
        add(st(0, BAD, 3'b000, 0, 0, 1), e_fetch(BAD, 1), m_all());
        add(st(0, BAD, 3'b000, 0, 0, 1), e_decode(BAD), m_all());
        add(st(0, BAD, 3'b000, 0, 0, 1), e_quiet(1), m_en());
        add(st(0, RT,  3'b000, 0, 0, 1), e_quiet(1), m_en());
        add(st(0, LW,  3'b000, 0, 0, 0), e_quiet(1), m_en());
        add_reset();
        add(st(0, BR, 3'b100, 0, 1, 1), e_fetch(BR, 1), m_all());
        add(st(0, BR, 3'b100, 0, 1, 1), e_decode(BR), m_all());
        add(st(0, BR, 3'b100, 0, 1, 1), e_quiet(1), m_en());
        add_reset();
        add_alu(RT, 3'b000, 1, 4'b1000);
        for (int i = 0; i < s_l.size(); i++) begin
            drive(s_l[i]);
            sb.push_back(e_l[i]);
            @(negedge clk);
            exp_o = sb.pop_front();
            n_cmp++;
            if ((dut_obs & m_l[i]) !== (exp_o & m_l[i])) begin
                n_bad++;
                $display("FAIL illegal cyc%0d got=%h want=%h", i, dut_obs & m_l[i], exp_o & m_l[i]);
            end
        end
    endtask

    task automatic test_timeout();
        clear_lists();
        // four stalled fetch cycles, then the trap
        for (int k = 0; k < 4; k++) add(st(0, RT, 3'b000, 0, 0, 0), e_fetch(RT, 0), m_all());
        add(st(0, RT, 3'b000, 0, 0, 0), e_quiet(1), m_en());
        add(st(0, RT, 3'b000, 0, 0, 1), e_quiet(1), m_en());
        add_reset();
        // ready on the fourth fetch cycle completes instead of trapping
        for (int k = 0; k < 3; k++) add(st(0, RT, 3'b000, 0, 0, 0), e_fetch(RT, 0), m_all());
        add(st(0, RT, 3'b000, 0, 0, 1), e_fetch(RT, 1), m_all());
        add(st(0, RT, 3'b000, 0, 0, 1), e_decode(RT), m_all());
        add(st(0, RT, 3'b000, 0, 0, 1), e_exec(RT, 2'b00, 4'b0000), m_all());
        add(st(0, RT, 3'b000, 0, 0, 1), e_wb(RT, 2'b00), m_all());
        // load that never completes traps out of MEMREAD
        add(st(0, LW, 3'b010, 0, 0, 1), e_fetch(LW, 1), m_all());
        add(st(0, LW, 3'b010, 0, 0, 1), e_decode(LW), m_all());
        add(st(0, LW, 3'b010, 0, 0, 1), e_memadr(LW), m_all());
        for (int k = 0; k < 4; k++) add(st(0, LW, 3'b010, 0, 0, 0), e_mem(LW, 0), m_all());
        add(st(0, LW, 3'b010, 0, 0, 1), e_quiet(1), m_en());
        add_reset();
        add(st(0, RT, 3'b000, 0, 0, 1), e_fetch(RT, 1), m_all());
        for (int i = 0; i < s_l.size(); i++) begin
            drive(s_l[i]);
            sb.push_back(e_l[i]);
            @(negedge clk);
            exp_o = sb.pop_front();
            n_cmp++;
            if ((dut_obs & m_l[i]) !== (exp_o & m_l[i])) begin
                n_bad++;
                $display("FAIL timeout cyc%0d got=%h want=%h", i, dut_obs & m_l[i], exp_o & m_l[i]);
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.i_op         = 7'd0;
        bus.i_funct3     = 3'd0;
        bus.i_funct7bit5 = 1'b0;
        bus.i_zero       = 1'b0;
        bus.i_memReady   = 1'b0;
        test_reset();
        test_alu();
        test_load_store();
        test_branch_jal();
        test_illegal();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
